// File: rtl/bt_poll_master.sv
// bt_poll_master: alternating X/Y request poller for the Bluetooth UART command/response link.
// Latency: reply byte to accel_x/accel_y + data_valid is 1 cycle; transmit pulse 1 cycle after SEND sees tx idle.
// Backpressure: holds in SEND while is_transmitting=1; replies/errors outside WAIT_RX are dropped.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   enable                run polling; deasserting stops after the current transaction
//   transmit, tx_byte     one-cycle send strobe and request code (1 = X/speed, 2 = Y/incline)
//   is_transmitting       UART transmitter busy
//   received, rx_byte     one-cycle reply strobe and reply byte
//   recv_error            UART framing error strobe
//   accel_x, accel_y      last good reply to code 1 / code 2
//   data_valid            one-cycle strobe when accel_x/accel_y updated
//   poll_fail             one-cycle strobe when a code exhausts its retries
//   ok_count, fail_count  saturating statistics, present only with POLL_STATS_EN defined
//
// Configuration macro: POLL_STATS_EN (undefined: ok_count/fail_count tied to zero).
module bt_poll_master #(
  parameter int unsigned POLL_INTERVAL  = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic [7:0]  accel_x,
  output logic [7:0]  accel_y,
  output logic        data_valid,
  output logic        poll_fail,
  output logic [15:0] ok_count,
  output logic [15:0] fail_count
);

  localparam int GAP_W = $clog2(POLL_INTERVAL + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_INTERVAL - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RT_W-1:0]  RETRY_MAX = RT_W'(MAX_RETRY);

  localparam logic [7:0] CODE_X = 8'd1;
  localparam logic [7:0] CODE_Y = 8'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GAP     = 2'd1,
    SEND    = 2'd2,
    WAIT_RX = 2'd3
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [RT_W-1:0]  retry;
  logic             code_y;   // 0: next/current request is X, 1: Y

  // A reply in the same cycle as a timeout or framing error counts as good.
  logic rx_hit;
  logic fail_hit;

  always_comb begin
    rx_hit   = (state == WAIT_RX) && received;
    fail_hit = (state == WAIT_RX) && !received && (recv_error || (to_cnt == TO_LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      retry      <= '0;
      code_y     <= 1'b0;
      transmit   <= 1'b0;
      tx_byte    <= CODE_X;
      accel_x    <= 8'd0;
      accel_y    <= 8'd0;
      data_valid <= 1'b0;
      poll_fail  <= 1'b0;
    end else begin
      transmit   <= 1'b0;
      data_valid <= 1'b0;
      poll_fail  <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end

        GAP: begin
          if (!enable) begin
            state <= IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        SEND: begin
          if (!is_transmitting) begin
            transmit <= 1'b1;
            tx_byte  <= code_y ? CODE_Y : CODE_X;
            to_cnt   <= '0;
            state    <= WAIT_RX;
          end
        end

        WAIT_RX: begin
          if (rx_hit) begin
            if (code_y) begin
              accel_y <= rx_byte;
            end else begin
              accel_x <= rx_byte;
            end
            data_valid <= 1'b1;
            retry      <= '0;
            code_y     <= ~code_y;
            gap_cnt    <= '0;
            state      <= enable ? GAP : IDLE;
          end else if (fail_hit) begin
            if (retry == RETRY_MAX) begin
              // Give up on this code and move on to the other axis.
              poll_fail <= 1'b1;
              retry     <= '0;
              code_y    <= ~code_y;
              gap_cnt   <= '0;
              state     <= enable ? GAP : IDLE;
            end else begin
              // Resend the same code straight away, no idle gap.
              retry <= retry + 1'b1;
              state <= SEND;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef POLL_STATS_EN
  logic [15:0] ok_q;
  logic [15:0] fail_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q   <= 16'd0;
      fail_q <= 16'd0;
    end else begin
      if (rx_hit && (ok_q != 16'hFFFF)) begin
        ok_q <= ok_q + 16'd1;
      end
      // Every failed attempt counts, including the ones that get retried.
      if (fail_hit && (fail_q != 16'hFFFF)) begin
        fail_q <= fail_q + 16'd1;
      end
    end
  end

  assign ok_count   = ok_q;
  assign fail_count = fail_q;
`else
  assign ok_count   = 16'd0;
  assign fail_count = 16'd0;
`endif

endmodule
